bcd_rr_arbiter: RTL and testbench
=================================

// Module: bcd_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource between up to ten decimal-indexed
//  requesters (e.g. keypad lines, ten display/BCD channels). Issues a one-hot
//  grant plus its 4-bit BCD index (0-9) so downstream BCD logic consumes it directly.
//  Holds the grant until release, drop of request, or hold timeout.
// PARAMETERS
//  N_REQ     10  active requesters, 1..10; req/gnt bits >= N_REQ unused (req ignored, gnt 0)
//  MAX_HOLD  8   max consecutive grant cycles before forced release; 0 = unlimited
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  req        in   10  request vector, bit i = requester i, level-sensitive
//  done       in   1   owner releases grant (sampled only in GRANT)
//  gnt        out  10  one-hot grant, registered
//  gnt_bcd    out  4   BCD index of granted bit, 0..9, registered
//  gnt_valid  out  1   high while any grant is asserted
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_bcd=0, gnt_valid=0.
//   rst overrides everything incl. an active grant; outputs zero the cycle after.
//  States: IDLE, GRANT (2-bit encoding, shared package).
//  IDLE: outputs 0. If any masked req bit set at edge: pick first set bit searching
//   ptr, ptr+1, ..., 9, 0, ..., ptr-1 (mod N_REQ); load gnt/gnt_bcd, gnt_valid=1,
//   hold_cnt=1 -> GRANT. Latency: req seen at edge k -> gnt valid after edge k.
//   No req: stay IDLE.
//  GRANT: outputs constant. Release at edge when any of: done=1; req[owner]=0;
//   MAX_HOLD!=0 and hold_cnt==MAX_HOLD. Else hold_cnt++ (saturates, no wrap).
//  Release: gnt=0, gnt_bcd=0, gnt_valid=0, ptr=owner+1 (owner==N_REQ-1 -> 0), -> IDLE.
//   Always exactly one dead IDLE cycle between grants; no back-to-back handover.
//  Other requests arriving during GRANT are not preempting; wait for release.
//  done while IDLE ignored. done+req[owner]=0 same edge: single release.
//  ptr range 0..N_REQ-1 only; gnt_bcd never > 9; gnt one-hot or zero always.
//  Invariant: gnt_valid == |gnt; gnt_bcd == index(gnt) when valid.
// STRUCTURE
//  Package bcd_arb_pkg: MAX_N=10, BCD_W=4, state localparams IDLE/GRANT.
//  Sub-module rr_pick10: combinational rotating-priority picker; in req[9:0], ptr[3:0];
//   out pick_oh[9:0], pick_bcd[3:0], pick_any. Top holds FSM, ptr, hold_cnt, out regs.
// TESTING
//  1 rst=1 two cycles, req=10'h3FF -> gnt=0, gnt_bcd=0, gnt_valid=0 throughout.
//  2 req=10'b0000100000 -> next cycle gnt=10'b0000100000, gnt_bcd=5, valid=1; done
//    pulse -> gnt=0 one cycle, then bcd=5 again (only requester, ptr=6).
//  3 req=10'h3FF, done=1 whenever valid -> gnt_bcd 0,1,2,...,9,0, idle cycle between each.
//  4 wrap: after grant of 9 released, req=10'b1000000001 -> gnt_bcd=0 (ptr wrapped to 0).
//  5 MAX_HOLD=4, req[3] and req[7] held, done=0 -> bcd=3 valid exactly 4 cycles,
//    1 idle, then bcd=7 for 4 cycles, then bcd=3.
//  6 rst=1 mid-grant of bcd=6 -> outputs 0 next cycle; req=10'h3FF -> next grant bcd=0.
//  Bench asserts one-hot/zero gnt, gnt_bcd<=9, gnt_valid==|gnt every cycle.

Source files
------------

// File: rtl/bcd_rr_arbiter_pkg.sv
// Shared constants, state encoding and pointer helper for the decimal round-robin arbiter.
package bcd_arb_pkg;

  localparam int MAX_N = 10;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } arb_state_e;

  // Next search start after releasing owner; wraps to 0 past the last active requester.
  function automatic logic [BCD_W-1:0] next_ptr(input logic [BCD_W-1:0] owner, input int n_req);
    return (int'(owner) >= n_req - 1) ? '0 : owner + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_rr_arbiter_rr_pick10.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping at N_REQ.
module rr_pick10
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = MAX_N
) (
  input  logic [MAX_N-1:0] req,
  input  logic [BCD_W-1:0] ptr,
  output logic [MAX_N-1:0] pick_oh,
  output logic [BCD_W-1:0] pick_bcd,
  output logic             pick_any
);

  logic [BCD_W:0]   sum;
  logic [BCD_W-1:0] idx;

  always_comb begin
    pick_oh  = '0;
    pick_bcd = '0;
    pick_any = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + 5'(k);
      if (sum >= 5'(N_REQ)) sum = sum - 5'(N_REQ);
      idx = sum[BCD_W-1:0];
      if (!pick_any && req[idx]) begin
        pick_any     = 1'b1;
        pick_oh[idx] = 1'b1;
        pick_bcd     = idx;
      end
    end
  end

endmodule

// File: rtl/bcd_rr_arbiter.sv
// Round-robin arbiter for up to ten requesters; grant is held until done, request drop
// or hold timeout, with one idle cycle between consecutive grants.
module bcd_rr_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ    = 10,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAX_N-1:0] req,
  input  logic             done,
  output logic [MAX_N-1:0] gnt,
  output logic [BCD_W-1:0] gnt_bcd,
  output logic             gnt_valid
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e        state_reg;
  logic [BCD_W-1:0]  ptr_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [MAX_N-1:0]  gnt_reg;
  logic [BCD_W-1:0]  gnt_bcd_reg;
  logic              gnt_valid_reg;

  logic [MAX_N-1:0]  req_masked;
  logic [MAX_N-1:0]  pick_oh;
  logic [BCD_W-1:0]  pick_bcd;
  logic              pick_any;
  logic              release_now;

  // Requesters at or above N_REQ never participate.
  for (genvar gi = 0; gi < MAX_N; gi++) begin : g_mask
    if (gi < N_REQ) begin : g_on
      assign req_masked[gi] = req[gi];
    end else begin : g_off
      assign req_masked[gi] = 1'b0;
    end
  end

  rr_pick10 #(.N_REQ(N_REQ)) u_pick (
    .req      (req_masked),
    .ptr      (ptr_reg),
    .pick_oh  (pick_oh),
    .pick_bcd (pick_bcd),
    .pick_any (pick_any)
  );

  assign release_now = done
                    || !req_masked[gnt_bcd_reg]
                    || ((MAX_HOLD != 0) && (hold_cnt_reg == HOLD_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= '0;
      gnt_bcd_reg   <= '0;
      gnt_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            gnt_reg       <= pick_oh;
            gnt_bcd_reg   <= pick_bcd;
            gnt_valid_reg <= 1'b1;
            hold_cnt_reg  <= HOLD_W'(1);
            state_reg     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt_reg       <= '0;
            gnt_bcd_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            hold_cnt_reg  <= '0;
            ptr_reg       <= next_ptr(gnt_bcd_reg, N_REQ);
            state_reg     <= IDLE;
          end else if (hold_cnt_reg != '1) begin
            hold_cnt_reg  <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        default: begin
          gnt_reg       <= '0;
          gnt_bcd_reg   <= '0;
          gnt_valid_reg <= 1'b0;
          hold_cnt_reg  <= '0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_bcd   = gnt_bcd_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_bcd_rr_arbiter.sv
// Directed bench for bcd_rr_arbiter (MAX_HOLD=4): expected grants are hand-derived per step,
// plus per-cycle structural invariants on the grant outputs.
module tb_bcd_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [9:0] req;
  logic       done;
  logic [9:0] gnt;
  logic [3:0] gnt_bcd;
  logic       gnt_valid;

  int n_assert = 0;
  int n_fail   = 0;
  bit inv_en   = 0;

  bcd_rr_arbiter #(.N_REQ(10), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_bcd   (gnt_bcd),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    $display("step %-12s rst=%0b req=%b done=%0b -> gnt=%b bcd=%0d valid=%0b",
             tag, rst, req, done, gnt, gnt_bcd, gnt_valid);
    n_assert++;
    assert (gnt === 10'd0) else begin
      n_fail++; $error("FAIL %s gnt: observed %b expected %b", tag, gnt, 10'd0);
    end
    n_assert++;
    assert (gnt_bcd === 4'd0) else begin
      n_fail++; $error("FAIL %s gnt_bcd: observed %0d expected 0", tag, gnt_bcd);
    end
    n_assert++;
    assert (gnt_valid === 1'b0) else begin
      n_fail++; $error("FAIL %s gnt_valid: observed %b expected 0", tag, gnt_valid);
    end
  endtask

  task automatic chk_gnt(input string tag, input int bcd);
    logic [9:0] eg;
    eg = 10'd1 << bcd;
    $display("step %-12s rst=%0b req=%b done=%0b -> gnt=%b bcd=%0d valid=%0b",
             tag, rst, req, done, gnt, gnt_bcd, gnt_valid);
    n_assert++;
    assert (gnt === eg) else begin
      n_fail++; $error("FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
    end
    n_assert++;
    assert (gnt_bcd === 4'(bcd)) else begin
      n_fail++; $error("FAIL %s gnt_bcd: observed %0d expected %0d", tag, gnt_bcd, bcd);
    end
    n_assert++;
    assert (gnt_valid === 1'b1) else begin
      n_fail++; $error("FAIL %s gnt_valid: observed %b expected 1", tag, gnt_valid);
    end
  endtask

  // Structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      n_assert++;
      assert ($onehot0(gnt)) else begin
        n_fail++; $error("FAIL inv_onehot: observed gnt=%b required one-hot or zero", gnt);
      end
      n_assert++;
      assert (gnt_bcd <= 4'd9) else begin
        n_fail++; $error("FAIL inv_bcd_range: observed %0d required <= 9", gnt_bcd);
      end
      n_assert++;
      assert (gnt_valid === (|gnt)) else begin
        n_fail++; $error("FAIL inv_valid: observed valid=%b required %b", gnt_valid, |gnt);
      end
      if (gnt_valid) begin
        n_assert++;
        assert (gnt[gnt_bcd] === 1'b1) else begin
          n_fail++; $error("FAIL inv_index: observed gnt=%b bcd=%0d required matching bit", gnt, gnt_bcd);
        end
      end
    end
  end

  initial begin
    // 1: reset holds outputs low even with every request set
    rst = 1'b1; req = 10'h3FF; done = 1'b0;
    tick(); inv_en = 1;
    chk_idle("rst_a");
    tick(); chk_idle("rst_b");
    rst = 1'b0; req = 10'd0;
    tick(); chk_idle("idle_noreq");

    // 2: single requester 5, done pulse, regrant after one idle cycle
    req = 10'b0000100000;
    tick(); chk_gnt("single5", 5);
    done = 1'b1;
    tick(); chk_idle("single5_rel");
    done = 1'b0;
    tick(); chk_gnt("single5_again", 5);
    done = 1'b1;
    tick(); chk_idle("single5_rel2");
    done = 1'b0; req = 10'd0;
    tick(); chk_idle("quiet");

    // 3: reset pointer, then full rotation 0..9 with done held high
    rst = 1'b1;
    tick(); chk_idle("rst_ptr");
    rst = 1'b0; req = 10'h3FF; done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk_gnt($sformatf("rot_g%0d", i), i);
      tick(); chk_idle($sformatf("rot_i%0d", i));
    end

    // 4: wrap after 9 released, then pointer at 1 skips to 9
    req = 10'b1000000001; done = 1'b0;
    tick(); chk_gnt("wrap0", 0);
    done = 1'b1;
    tick(); chk_idle("wrap0_rel");
    done = 1'b0;
    tick(); chk_gnt("wrap9", 9);
    done = 1'b1;
    tick(); chk_idle("wrap9_rel");
    done = 1'b0; req = 10'd0;
    tick(); chk_idle("quiet2");

    // request drop releases the grant
    req = 10'b0000000100;
    tick(); chk_gnt("drop2", 2);
    req = 10'd0;
    tick(); chk_idle("drop2_rel");

    // no preemption; done with owner drop on the same edge releases once
    req = 10'b0000010000;
    tick(); chk_gnt("hold4", 4);
    req = 10'b0000010010;
    tick(); chk_gnt("nopreempt", 4);
    req = 10'b0000000010; done = 1'b1;
    tick(); chk_idle("dual_rel");
    done = 1'b0;
    tick(); chk_gnt("after_dual", 1);
    req = 10'd0;
    tick(); chk_idle("quiet3");

    // 5: hold timeout of 4 cycles alternates between 3 and 7 (ptr=2)
    req = 10'b0010001000;
    for (int c = 0; c < 4; c++) begin
      tick(); chk_gnt($sformatf("to3_c%0d", c), 3);
    end
    tick(); chk_idle("to3_rel");
    for (int c = 0; c < 4; c++) begin
      tick(); chk_gnt($sformatf("to7_c%0d", c), 7);
    end
    tick(); chk_idle("to7_rel");
    tick(); chk_gnt("to3_back", 3);

    // 6: reset in the middle of a grant of 6
    req = 10'd0;
    tick(); chk_idle("pre6_rel");
    req = 10'b0001000000;
    tick(); chk_gnt("g6", 6);
    tick(); chk_gnt("g6_hold", 6);
    rst = 1'b1; req = 10'h3FF;
    tick(); chk_idle("rst_mid");
    rst = 1'b0;
    tick(); chk_gnt("post_rst", 0);
    req = 10'd0;
    tick(); chk_idle("final");

    inv_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
